fetch_stage: RTL

- Instruction-fetch stage of the 5-stage MIPS pipeline; the producer side of the IF/ID interface consumed by the decode stage.
- Owns the PC, issues instruction-memory reads, and hands decode each instruction (instru) with its PC+4 (nPC) on an ihit.
- Honours hazard-unit stalls and branch/jump redirects, and stops fetching once a halt opcode (6'b111111) is fetched.

---
 rtl/fetch_stage.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads instruction memory, fills the IF/ID register.
// Latency: IF/ID is updated on the rising edge after an ihit; flush is combinational (0 cycles).
// Backpressure: stall holds PC and IF/ID; ihit low holds IF/ID; no fetch while draining a halt.
//
// Ports:
//   CLK, nRST          clock (rising edge) and asynchronous active-low reset
//   ihit, iload        memory returns iload this cycle
//   imemREN, imemaddr  read request and word-aligned read address
//   stall              hazard-unit hold
//   redirect(_pc)      branch/jump resolved downstream, with its target
//   halt_seen          decode has latched the halt
//   instru, nPC, valid IF/ID contents handed to decode
//   flush              decode must clear its IF/ID copy
//   halted             fetch permanently stopped until reset
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h00000000,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt_seen,
  output logic [31:0] instru,
  output logic [31:0] nPC,
  output logic        valid,
  output logic        flush,
  output logic        halted
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] instru_r, instru_nxt;
  logic [31:0] npc_r, npc_nxt;
  logic        valid_r, valid_nxt;
  logic [31:0] pc_inc;

  // Natural 32-bit wrap: 0xFFFFFFFC + 4 = 0.
  assign pc_inc = pc + 32'd4;

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    instru_nxt = instru_r;
    npc_nxt    = npc_r;
    valid_nxt  = valid_r;
    case (state)
      RUN: begin
        if (redirect) begin
          // Redirect squashes whatever ihit arrives in the same cycle.
          pc_nxt     = redirect_pc & ~32'h3;
          instru_nxt = 32'h0;
          npc_nxt    = 32'h0;
          valid_nxt  = 1'b0;
        end else if (halt_seen) begin
          state_nxt = HALTED;
        end else if (!stall && ihit) begin
          instru_nxt = iload;
          npc_nxt    = pc_inc;
          valid_nxt  = 1'b1;
          // A fetched halt parks the PC; nothing past it may be fetched.
          if (iload[31:26] == HALT_OP) state_nxt = DRAIN;
          else                         pc_nxt    = pc_inc;
        end
      end
      DRAIN: begin
        if (redirect) begin
          // An older branch resolved after the halt was fetched: the halt was speculative.
          pc_nxt     = redirect_pc & ~32'h3;
          instru_nxt = 32'h0;
          npc_nxt    = 32'h0;
          valid_nxt  = 1'b0;
          state_nxt  = RUN;
        end else if (halt_seen) begin
          state_nxt = HALTED;
        end
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= RUN;
      pc       <= PC_INIT;
      instru_r <= 32'h0;
      npc_r    <= 32'h0;
      valid_r  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      instru_r <= instru_nxt;
      npc_r    <= npc_nxt;
      valid_r  <= valid_nxt;
    end
  end

  assign imemaddr = {pc[31:2], 2'b00};
  assign imemREN  = (state == RUN);
  assign halted   = (state == HALTED);
  assign flush    = redirect && (state != HALTED);
  // Once halted, decode must never see a live instruction.
  assign instru   = (state == HALTED) ? 32'h0 : instru_r;
  assign valid    = (state == HALTED) ? 1'b0  : valid_r;
  assign nPC      = npc_r;

endmodule
